// File: rtl/pc_branch_unit.sv
// Program-counter / branch unit: sequential PC, two-cycle branch and jump
// resolution, link writes, and a circular return-address stack checker.
module pc_branch_unit #(
  parameter int unsigned     PC_W      = 32,
  parameter int unsigned     DATA_W    = 32,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter int unsigned     RAS_DEPTH = 4,
  localparam int unsigned    CNT_W     = $clog2(RAS_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              finish,
  input  logic [31:0]       opcode,
  input  logic [31:0]       flag,
  input  logic [PC_W-1:0]   alu_rd,
  output logic              pcir_cs,
  output logic [PC_W-1:0]   program_count,
  output logic              reg_we,
  output logic [4:0]        waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              ras_valid,
  output logic              ras_hit,
  output logic [CNT_W-1:0]  ras_count
);

  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;
  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;

  typedef enum logic {S_EXEC, S_RESOLVE} state_e;

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [31:0]         instr_q, instr_d;
  logic                cs_q, cs_d;
  logic                we_q, we_d;
  logic [4:0]          waddr_q, waddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                rv_q, rv_d;
  logic                rh_q, rh_d;
  logic [PTR_W-1:0]    ras_wr_q, ras_wr_d;
  logic [CNT_W-1:0]    ras_cnt_q, ras_cnt_d;
  logic [PC_W-1:0]     ras_mem [RAS_DEPTH];
  logic                ras_push, ras_pop, taken;

  logic [5:0]          ex_op, ex_fn, rs_op, rs_fn;
  logic                zero, sign;
  logic [PC_W-1:0]     pc_plus4, br_tgt, ex_jtgt, rs_jtgt;
  logic [PTR_W-1:0]    ras_top_idx, ras_next_idx;
  logic                unused_flag;

  assign ex_op    = opcode[31:26];
  assign ex_fn    = opcode[5:0];
  assign rs_op    = instr_q[31:26];
  assign rs_fn    = instr_q[5:0];
  assign zero     = flag[0];
  assign sign     = flag[4];
  assign unused_flag = ^{flag[31:5], flag[3:1]};

  assign pc_plus4 = pc_q + PC_W'(4);
  assign br_tgt   = pc_q + {{(PC_W-18){instr_q[15]}}, instr_q[15:0], 2'b00};
  assign ex_jtgt  = {pc_q[PC_W-1:28], opcode[25:0], 2'b00};
  assign rs_jtgt  = {pc_q[PC_W-1:28], instr_q[25:0], 2'b00};

  // Circular pointer arithmetic for non-power-of-two depths.
  assign ras_top_idx  = (ras_wr_q == '0) ? PTR_W'(RAS_DEPTH - 1) : ras_wr_q - PTR_W'(1);
  assign ras_next_idx = (ras_wr_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : ras_wr_q + PTR_W'(1);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    cs_d      = 1'b1;
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    rv_d      = 1'b0;
    rh_d      = 1'b0;
    ras_push  = 1'b0;
    ras_pop   = 1'b0;
    taken     = 1'b0;
    ras_wr_d  = ras_wr_q;
    ras_cnt_d = ras_cnt_q;

    case (state_q)
      S_EXEC: begin
        if (finish) begin
          cs_d    = 1'b0;
          instr_d = opcode;
          case (ex_op)
            OP_J: pc_d = ex_jtgt;
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_REGIMM: state_d = S_RESOLVE;
            OP_JAL: begin
              state_d  = S_RESOLVE;
              we_d     = 1'b1;
              waddr_d  = 5'd31;
              wdata_d  = DATA_W'(pc_plus4);
              ras_push = 1'b1;
            end
            OP_SPECIAL: begin
              if (ex_fn == FN_JR) begin
                state_d = S_RESOLVE;
              end else if (ex_fn == FN_JALR) begin
                state_d  = S_RESOLVE;
                we_d     = 1'b1;
                waddr_d  = opcode[15:11];
                wdata_d  = DATA_W'(pc_plus4);
                ras_push = 1'b1;
              end else begin
                pc_d = pc_plus4;
              end
            end
            default: pc_d = pc_plus4;
          endcase
        end
      end
      S_RESOLVE: begin
        cs_d    = 1'b0;
        state_d = S_EXEC;
        case (rs_op)
          OP_BEQ:    taken = zero;
          OP_BNE:    taken = !zero;
          OP_BLEZ:   taken = sign || zero;
          OP_BGTZ:   taken = !sign && !zero;
          OP_REGIMM: taken = (instr_q[20:16] == 5'd1) ? !sign :
                             (instr_q[20:16] == 5'd0) ? sign : 1'b0;
          default:   taken = 1'b0;
        endcase
        pc_d = taken ? br_tgt : pc_plus4;
        if (rs_op == OP_JAL) begin
          pc_d = rs_jtgt;
        end else if (rs_op == OP_SPECIAL) begin
          pc_d = alu_rd;
          // Only JR $31 is treated as a return; the stack never steers the PC.
          if (rs_fn == FN_JR && instr_q[25:21] == 5'd31) begin
            rv_d = 1'b1;
            if (ras_cnt_q != '0) begin
              ras_pop = 1'b1;
              rh_d    = (ras_mem[ras_top_idx] == alu_rd);
            end
          end
        end
      end
      default: state_d = S_EXEC;
    endcase

    if (ras_push) begin
      ras_wr_d = ras_next_idx;
      if (ras_cnt_q != CNT_W'(RAS_DEPTH)) ras_cnt_d = ras_cnt_q + CNT_W'(1);
    end else if (ras_pop) begin
      ras_wr_d  = ras_top_idx;
      ras_cnt_d = ras_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_EXEC;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      cs_q      <= 1'b1;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      rv_q      <= 1'b0;
      rh_q      <= 1'b0;
      ras_wr_q  <= '0;
      ras_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      cs_q      <= cs_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      rv_q      <= rv_d;
      rh_q      <= rh_d;
      ras_wr_q  <= ras_wr_d;
      ras_cnt_q <= ras_cnt_d;
    end
  end

  // Stack storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clk) begin
    if (!rst && ras_push) ras_mem[ras_wr_q] <= pc_plus4;
  end

  assign pcir_cs       = cs_q;
  assign program_count = pc_q;
  assign reg_we        = we_q;
  assign waddr         = waddr_q;
  assign wdata         = wdata_q;
  assign ras_valid     = rv_q;
  assign ras_hit       = rh_q;
  assign ras_count     = ras_cnt_q;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Bench for pc_branch_unit: directed scenarios plus randomized instruction
// streams checked against a transaction-level reference model.
module tb_pc_branch_unit;

  localparam int unsigned PC_W   = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 2;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam logic [31:0] RPC    = 32'h100;
  localparam logic [31:0] JR31   = 32'h03E00008;

  logic              clk = 1'b0;
  logic              rst, finish;
  logic [31:0]       opcode, flag;
  logic [PC_W-1:0]   alu_rd;
  logic              pcir_cs, reg_we, ras_valid, ras_hit;
  logic [PC_W-1:0]   program_count;
  logic [4:0]        waddr;
  logic [DATA_W-1:0] wdata;
  logic [CNT_W-1:0]  ras_count;

  always #5 clk = ~clk;

  pc_branch_unit #(
    .PC_W(PC_W), .DATA_W(DATA_W), .RESET_PC(RPC), .RAS_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .finish(finish), .opcode(opcode), .flag(flag),
    .alu_rd(alu_rd), .pcir_cs(pcir_cs), .program_count(program_count),
    .reg_we(reg_we), .waddr(waddr), .wdata(wdata), .ras_valid(ras_valid),
    .ras_hit(ras_hit), .ras_count(ras_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: architectural PC, a pending control instruction, and the RAS as a queue.
  bit [31:0] m_pc, m_instr, m_wdata;
  bit        m_pend, m_cs, m_we, m_rv, m_rh, m_rst_seen;
  bit [4:0]  m_waddr;
  bit [31:0] m_ras [$];

  function automatic bit [31:0] jtgt(input bit [31:0] pc, input bit [31:0] ins);
    return {pc[31:28], ins[25:0], 2'b00};
  endfunction

  function automatic bit [31:0] boff(input bit [31:0] ins);
    return {{14{ins[15]}}, ins[15:0], 2'b00};
  endfunction

  function automatic bit is_jr31(input bit [31:0] ins);
    return ins[31:26] == 6'd0 && ins[5:0] == 6'h08 && ins[25:21] == 5'd31;
  endfunction

  task automatic ras_push(input bit [31:0] v);
    m_ras.push_back(v);
    if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
  endtask

  task automatic model_edge();
    bit [5:0] op;
    bit       z, s, tk;
    bit [4:0] rt;
    m_rst_seen = 1'b0;
    m_rv = 1'b0;
    m_rh = 1'b0;
    m_we = 1'b0;
    if (rst) begin
      m_pc = RPC; m_cs = 1'b1; m_waddr = '0; m_wdata = '0;
      m_pend = 1'b0; m_rst_seen = 1'b1;
      m_ras.delete();
    end else if (m_pend) begin
      m_cs = 1'b0; m_pend = 1'b0;
      op = m_instr[31:26]; z = flag[0]; s = flag[4]; rt = m_instr[20:16];
      tk = 1'b0;
      case (op)
        6'd4: tk = z;
        6'd5: tk = !z;
        6'd6: tk = s || z;
        6'd7: tk = !s && !z;
        6'd1: tk = (rt == 5'd1) ? !s : (rt == 5'd0) ? s : 1'b0;
        default: tk = 1'b0;
      endcase
      if (op == 6'd3) m_pc = jtgt(m_pc, m_instr);
      else if (op == 6'd0) begin
        if (is_jr31(m_instr)) begin
          m_rv = 1'b1;
          if (m_ras.size() > 0) m_rh = (m_ras.pop_back() == alu_rd);
        end
        m_pc = alu_rd;
      end else m_pc = tk ? m_pc + boff(m_instr) : m_pc + 32'd4;
    end else if (finish) begin
      m_cs = 1'b0;
      op = opcode[31:26];
      if (op == 6'd2) m_pc = jtgt(m_pc, opcode);
      else if (op == 6'd1 || (op >= 6'd4 && op <= 6'd7)) begin
        m_pend = 1'b1; m_instr = opcode;
      end else if (op == 6'd3 || (op == 6'd0 && opcode[5:0] == 6'h09)) begin
        m_pend = 1'b1; m_instr = opcode; m_we = 1'b1;
        m_waddr = (op == 6'd3) ? 5'd31 : opcode[15:11];
        m_wdata = m_pc + 32'd4;
        ras_push(m_pc + 32'd4);
      end else if (op == 6'd0 && opcode[5:0] == 6'h08) begin
        m_pend = 1'b1; m_instr = opcode;
      end else m_pc = m_pc + 32'd4;
    end else begin
      m_cs = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("pc", 64'(program_count), 64'(m_pc));
    check("pcir_cs", 64'(pcir_cs), 64'(m_cs));
    check("reg_we", 64'(reg_we), 64'(m_we));
    check("ras_valid", 64'(ras_valid), 64'(m_rv));
    check("ras_count", 64'(ras_count), 64'(m_ras.size()));
    if (m_we || m_rst_seen) begin
      check("waddr", 64'(waddr), 64'(m_waddr));
      check("wdata", 64'(wdata), 64'(m_wdata));
    end
    if (m_rv || m_rst_seen) check("ras_hit", 64'(ras_hit), 64'(m_rh));
  endtask

  task automatic drive(input bit f, input bit [31:0] op, input bit [31:0] fl, input bit [31:0] ard);
    finish = f; opcode = op; flag = fl; alu_rd = ard;
  endtask

  // Move the PC anywhere with a JR through a register other than $31.
  task automatic set_pc(input bit [31:0] t);
    drive(1'b1, 32'h00200008, 32'h0, t);
    step();
    drive(1'b0, 32'h0, 32'h0, t);
    step();
  endtask

  function automatic bit [31:0] gen_instr();
    bit [31:0] r;
    int        k;
    int        sel;
    r = $urandom;
    k = $urandom_range(0, 9);
    case (k)
      0: begin
        if ($urandom_range(0, 1) == 0) r[31:26] = 6'($urandom_range(8, 63));
        else begin r[31:26] = 6'd0; r[5:0] = 6'h21; end
      end
      1: r[31:26] = 6'd2;
      2, 3, 4, 5: r[31:26] = 6'(k + 2);
      6: begin
        r[31:26] = 6'd1;
        sel = $urandom_range(0, 2);
        if (sel < 2) r[20:16] = 5'(sel);
      end
      7: begin
        r = {6'd0, 5'($urandom), 15'd0, 6'h08};
        if ($urandom_range(0, 1) == 0) r[25:21] = 5'd31;
      end
      8: r[31:26] = 6'd3;
      default: r = {6'd0, 5'($urandom), 5'd0, 5'($urandom), 5'd0, 6'h09};
    endcase
    return r;
  endfunction

  logic [31:0] rets [3];
  logic        hits [3];
  logic [31:0] rt_op;
  logic [31:0] rt_exp [3];

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    step();
    check("rst_pc", 64'(program_count), 64'(RPC));
    check("rst_cs", 64'(pcir_cs), 64'd1);
    check("rst_cnt", 64'(ras_count), 64'd0);
    rst = 1'b0;

    drive(1'b1, 32'h00000020, 32'h0, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      step();
      check("seq_pc", 64'(program_count), 64'(32'h100 + 32'(4 * i)));
    end
    drive(1'b0, 32'h00000020, 32'h0, 32'h0);
    step();
    check("hold_pc", 64'(program_count), 64'h10C);
    check("hold_cs", 64'(pcir_cs), 64'd1);

    set_pc(32'h40);
    drive(1'b1, 32'h1000FFFE, 32'h0, 32'h0);
    step();
    check("beq_hold", 64'(program_count), 64'h40);
    drive(1'b0, 32'h1000FFFE, 32'h1, 32'h0);
    step();
    check("beq_taken", 64'(program_count), 64'h38);
    set_pc(32'h40);
    drive(1'b1, 32'h1000FFFE, 32'h0, 32'h0);
    step();
    step();
    check("beq_ntaken", 64'(program_count), 64'h44);

    rt_exp[0] = 32'h30; rt_exp[1] = 32'h24; rt_exp[2] = 32'h24;
    for (int i = 0; i < 3; i++) begin
      set_pc(32'h20);
      rt_op = 32'h04000004;
      rt_op[20:16] = (i == 2) ? 5'd3 : 5'(i);
      drive(1'b1, rt_op, 32'h10, 32'h0);
      step();
      step();
      check("regimm_pc", 64'(program_count), 64'(rt_exp[i]));
    end

    set_pc(32'h10000010);
    drive(1'b1, 32'h0C000040, 32'h0, 32'h0);
    step();
    check("jal_we", 64'(reg_we), 64'd1);
    check("jal_waddr", 64'(waddr), 64'd31);
    check("jal_wdata", 64'(wdata), 64'h10000014);
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    step();
    check("jal_pc", 64'(program_count), 64'h10000100);
    check("jal_cnt", 64'(ras_count), 64'd1);
    drive(1'b1, JR31, 32'h0, 32'h0);
    step();
    drive(1'b0, JR31, 32'h0, 32'h10000014);
    step();
    check("jr_valid", 64'(ras_valid), 64'd1);
    check("jr_hit", 64'(ras_hit), 64'd1);
    check("jr_pc", 64'(program_count), 64'h10000014);
    check("jr_cnt", 64'(ras_count), 64'd0);
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    step();
    check("jr_pulse", 64'(ras_valid), 64'd0);

    set_pc(32'h10000010);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h0C000000 | 32'(32'h40 * (i + 1)), 32'h0, 32'h0);
      step();
      drive(1'b0, 32'h0, 32'h0, 32'h0);
      step();
    end
    check("wrap_cnt", 64'(ras_count), 64'd2);
    rets[0] = 32'h10000204; rets[1] = 32'h10000104; rets[2] = 32'h10000014;
    hits[0] = 1'b1; hits[1] = 1'b1; hits[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, JR31, 32'h0, 32'h0);
      step();
      drive(1'b0, JR31, 32'h0, rets[i]);
      step();
      check("wrap_valid", 64'(ras_valid), 64'd1);
      check("wrap_hit", 64'(ras_hit), 64'(hits[i]));
      check("wrap_pc", 64'(program_count), 64'(rets[i]));
      check("wrap_cnt2", 64'(ras_count), (i == 0) ? 64'd1 : 64'd0);
    end

    set_pc(32'h40);
    drive(1'b1, 32'h14000010, 32'h0, 32'h0);
    step();
    rst = 1'b1;
    step();
    check("abort_pc", 64'(program_count), 64'(RPC));
    check("abort_cs", 64'(pcir_cs), 64'd1);
    rst = 1'b0;
    drive(1'b1, 32'h00000020, 32'h0, 32'h0);
    step();
    check("abort_exec", 64'(program_count), 64'h104);

    for (int c = 0; c < 3000; c++) begin
      rst    = ($urandom_range(0, 99) == 0);
      finish = ($urandom_range(0, 4) != 0);
      opcode = gen_instr();
      flag   = $urandom;
      alu_rd = $urandom;
      if (m_pend && is_jr31(m_instr) && m_ras.size() > 0 && $urandom_range(0, 1) == 1)
        alu_rd = m_ras[m_ras.size() - 1];
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_branch_unit.md
Name: pc_branch_unit

Overview:
- Parametrised next-generation program-counter / branch unit.
- Sits between instruction fetch (opcode, finish) and the ALU flag/result path, and drives the register-file write port for link writes.
- Adds configurable PC width and reset vector.
- Decodes BGEZ and BLTZ separately via the rt field.
- Adds a circular return-address stack (RAS) that checks JR $31 targets and reports hit or miss.

Parameters:
- PC_W, 32, PC width in bits. Legal range 29..DATA_W.
- DATA_W, 32, register-file data width. The link value is zero-extended to this width.
- RESET_PC, 0, program_count value after reset. Must be a multiple of 4.
- RAS_DEPTH, 4, RAS entries. Legal range 1..16.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- finish  in  1  opcode valid; the unit advances only while high.
- opcode  in  32  current instruction.
- flag  in  32  ALU flags: bit0 zero, bit4 sign.
- alu_rd  in  PC_W  rs value for JR/JALR targets.
- pcir_cs  out  1  low = unit active this cycle.
- program_count  out  PC_W  current PC.
- reg_we  out  1  register-file write enable, active-high.
- waddr  out  5  link register address.
- wdata  out  DATA_W  link value.
- ras_valid  out  1  one-cycle pulse when a JR $31 is checked against the RAS.
- ras_hit  out  1  valid when ras_valid is high: popped entry == alu_rd.
- ras_count  out  clog2(RAS_DEPTH+1)  current RAS occupancy.

Behaviour:
- Reset (rst=1 at a rising edge), wins over everything:
  - program_count=RESET_PC, pcir_cs=1, reg_we=0, waddr=0, wdata=0.
  - ras_valid=0, ras_hit=0, ras_count=0, FSM=EXEC.
  - Reset mid-sequence abandons any pending branch or link.
- FSM states: EXEC and RESOLVE.
- EXEC with finish=0: all state holds, pcir_cs=1, reg_we=0.
- EXEC with finish=1: pcir_cs=0, then decode {opcode[31:26], opcode[5:0]}:
  - Non-control: pc += 4. Stay in EXEC. Latency 1.
  - J (000010): pc = {pc[PC_W-1:28], opcode[25:0], 2'b00}. Latency 1.
  - BEQ, BNE, BLEZ, BGTZ, REGIMM (000001), JR, JAL, JALR: hold pc, go to RESOLVE.
  - JAL in its EXEC cycle: reg_we=1, waddr=31, wdata=pc+4. RAS push of pc+4.
  - JALR in its EXEC cycle: reg_we=1, waddr=opcode[15:11], wdata=pc+4. RAS push of pc+4.
- RESOLVE: finish is ignored; flags and alu_rd are sampled this cycle; reg_we=0; return to EXEC.
  - Taken branch: pc += sext(opcode[15:0])<<2, sign-extended to PC_W. Not taken: pc += 4.
  - BEQ taken if zero. BNE taken if !zero.
  - BGTZ taken if !sign && !zero. BLEZ taken if sign || zero.
  - REGIMM: rt=00001 is BGEZ, taken if !sign. rt=00000 is BLTZ, taken if sign. Any other rt: pc += 4.
  - JR/JALR: pc = alu_rd.
  - JAL: pc = {pc[PC_W-1:28], opcode[25:0], 2'b00}.
- RAS checking:
  - JR with rs=31 in RESOLVE: ras_valid=1 for one cycle.
  - If ras_count>0: pop, and ras_hit = (popped entry == alu_rd).
  - If empty: no pop, ras_hit=0.
  - The RAS is only a checker; the PC always follows alu_rd.
- RAS full/wrap:
  - Push when full overwrites the oldest entry (circular); ras_count stays at RAS_DEPTH.
  - Push and pop never coincide, because they occur in different states.
- Arithmetic:
  - All PC arithmetic is modulo 2^PC_W; wrap past all-ones is silent.
  - wdata = zero-extended pc+4.
- Outputs are registered; a new PC is visible the cycle after the deciding edge.

Test Plan:
- Reset with RESET_PC=0x100, then non-control opcode 0x00000020 with finish=1 for 3 cycles:
  - program_count goes 0x100 → 0x104 → 0x108 → 0x10C.
  - finish=0 then holds the PC.
- BEQ at pc=0x40 with offset 0xFFFE:
  - zero=1 in RESOLVE: pc=0x38, two cycles total.
  - Repeat with zero=0: pc=0x44.
- REGIMM at pc=0x20, offset 4, sign=1:
  - rt=00000 (BLTZ): pc=0x30.
  - rt=00001 (BGEZ): pc=0x24.
  - rt=00011: pc=0x24.
- JAL at pc=0x10000010 with index 0x40:
  - Cycle 1: reg_we=1, waddr=31, wdata=0x10000014.
  - Cycle 2: pc=0x10000100; ras_count=1.
  - Then JR $31 with alu_rd=0x10000014: ras_valid=1, ras_hit=1, pc=0x10000014, ras_count=0.
- RAS_DEPTH=2, three JALs, then three JR $31:
  - Hits on the 2nd and 3rd return addresses only.
  - The third JR gives ras_valid=1, ras_hit=0, ras_count stays 0.
- Assert rst in RESOLVE of a BNE: next cycle pc=RESET_PC, FSM=EXEC, no PC update from the aborted branch.
